iobuf_ctrl: RTL
===============

Name: iobuf_ctrl

Overview:
Half-duplex sequencer for a single bidirectional pad built from the team's iobuf (obuf/ibuf pair).
- Arbitrates between a transmit requester and a receive requester, round-robin.
- TX: serialises words onto the pad. RX: samples words from the pad.
- Inserts a turnaround gap with output enable low after every transfer, so no two drivers ever contend.
- Sits between core-side logic and the iobuf's a/oe/y pins.

Parameters:
- DATA_W, 8: bits per transfer word (>=1).
- BIT_CYCLES, 4: clocks per serial bit (>=2).
- TURN_CYCLES, 2: clocks of oe-low gap after each transfer (>=1).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  asynchronous active-high reset.
- tx_data  input  DATA_W  word to send, MSB first.
- tx_valid  input  1  TX request.
- tx_ready  output  1  TX accept; handshake = tx_valid & tx_ready.
- rx_req  input  1  level request to open an RX window.
- rx_data  output  DATA_W  last received word, MSB first.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rx_perr  output  1  parity error flag (see Optional Feature).
- pad_o  output  1  to iobuf a.
- pad_oe  output  1  to iobuf oe.
- pad_i  input  1  from iobuf y.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- States: IDLE, TX, RX, TURN. Reset state is IDLE.
- Reset values: pad_oe=0, pad_o=0, rx_data=0, rx_valid=0, rx_perr=0, busy=0, tx_ready=1. Round-robin pointer favours TX.
- pad_oe is a registered output. Reset clears it asynchronously, so a mid-transfer reset releases the pad immediately.
- tx_ready = (state==IDLE) and (TX wins arbitration or rx_req=0). It is high only in IDLE.
- Arbitration in IDLE:
  - Only tx_valid: grant TX.
  - Only rx_req: grant RX.
  - Both: grant the side not granted last. After reset, TX wins.
  - Pointer updates on each grant.
- TX:
  - On handshake, latch tx_data and enter TX the next cycle.
  - pad_oe=1 for exactly DATA_W*BIT_CYCLES cycles.
  - Bit k (MSB first) is held on pad_o for BIT_CYCLES cycles.
  - Then enter TURN.
- RX:
  - pad_oe stays 0 throughout.
  - Bit k is sampled from pad_i at cycle offset k*BIT_CYCLES + BIT_CYCLES/2 (integer division) after RX entry, shifting MSB first.
  - After DATA_W*BIT_CYCLES cycles, enter TURN.
  - rx_data and rx_valid update on the first TURN cycle.
- TURN:
  - pad_oe=0 for TURN_CYCLES cycles, then IDLE.
  - tx_ready rises on the cycle after the last TURN cycle.
  - TURN follows RX as well as TX.
- TX occupancy: from handshake cycle H, pad_oe is high for cycles H+1 .. H+DATA_W*BIT_CYCLES.
- rx_valid has no backpressure. rx_data holds until the next RX completes.
- tx_valid deasserted before a handshake has no effect.
- rx_req is sampled only in IDLE. Dropping it mid-RX does not abort the window.
- tx_data changes after the handshake are ignored.
- pad_o is driven 0 whenever pad_oe=0.

Optional Feature:
Macro IOBUF_CTRL_PARITY_EN.
- Defined:
  - TX appends one even-parity bit after the data bits, so pad_oe is high (DATA_W+1)*BIT_CYCLES cycles.
  - RX samples one extra bit. rx_perr updates with rx_valid: 1 if received parity mismatches, else 0.
- Undefined: transfers are exactly DATA_W bits and rx_perr is tied 0.

Decomposition:
- Package iobuf_ctrl_pkg: state enum (IDLE, TX, RX, TURN) and default parameter constants.
- One sub-module, iobuf_ctrl_timer: bit-cycle counter plus bit index counter.
  - Outputs: bit_strobe, sample_strobe, last_bit.
  - Reused by both TX and RX.

Test Plan (DATA_W=8, BIT_CYCLES=4, TURN_CYCLES=2):
- Reset held, then released -> pad_oe=0, tx_ready=1, busy=0, rx_valid=0.
- TX 0xA5 -> pad_o=1,0,1,0,0,1,0,1, each bit for 4 cycles; pad_oe high 32 cycles then low 2; tx_ready returns at H+35.
- rx_req=1 with bench driving 0x3C at 4 cycles/bit -> single rx_valid pulse with rx_data=0x3C; pad_oe never 1.
- tx_valid and rx_req both held after reset -> grant order TX, RX, TX; pad_oe low for 2 cycles between every pair of transfers.
- rst asserted at cycle 10 of a TX -> pad_oe drops to 0 before the next clock edge; state IDLE, tx_ready=1 after release.
- With IOBUF_CTRL_PARITY_EN:
  - TX 0x07 -> 9 bits, last bit 1.
  - RX 0x07 with parity bit 0 -> rx_perr=1.
  - RX 0x07 with parity bit 1 -> rx_perr=0.

Source files
------------

// File: rtl/iobuf_ctrl_pkg.sv
// Shared types and defaults for the iobuf_ctrl half-duplex pad sequencer.
package iobuf_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_RX   = 2'd2,
        ST_TURN = 2'd3
    } state_e;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_BIT_CYCLES  = 4;
    localparam int DEF_TURN_CYCLES = 2;

    // Counter width for a count of n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iobuf_ctrl_timer.sv
// Bit timing for serial transfers: down-counts clocks within a bit and bits within a frame.
module iobuf_ctrl_timer
    import iobuf_ctrl_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int NBITS      = DEF_DATA_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic run_i,
    output logic bit_strobe_o,
    output logic sample_strobe_o,
    output logic last_bit_o
);

    localparam int CW = cnt_w(BIT_CYCLES);
    localparam int IW = cnt_w(NBITS);
    localparam logic [CW-1:0] CYC_LOAD   = CW'(BIT_CYCLES - 1);
    // cyc_q counts down, so offset BIT_CYCLES/2 into a bit is this terminal value
    localparam logic [CW-1:0] CYC_SAMPLE = CW'(BIT_CYCLES - 1 - BIT_CYCLES / 2);
    localparam logic [IW-1:0] IDX_LOAD   = IW'(NBITS - 1);

    logic [CW-1:0] cyc_q;
    logic [IW-1:0] idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            idx_q <= '0;
        end else if (start_i) begin
            cyc_q <= CYC_LOAD;
            idx_q <= IDX_LOAD;
        end else if (run_i) begin
            if (cyc_q == '0) begin
                cyc_q <= CYC_LOAD;
                if (idx_q != '0) idx_q <= idx_q - IW'(1);
            end else begin
                cyc_q <= cyc_q - CW'(1);
            end
        end
    end

    assign bit_strobe_o    = run_i && (cyc_q == '0);
    assign sample_strobe_o = run_i && (cyc_q == CYC_SAMPLE);
    assign last_bit_o      = (idx_q == '0);

endmodule

// File: rtl/iobuf_ctrl.sv
// Half-duplex sequencer for one bidirectional pad with round-robin TX/RX arbitration.
// Define IOBUF_CTRL_PARITY_EN to append/check an even-parity bit on every transfer.
//   state | meaning
//   IDLE  | arbitrate tx_valid vs rx_req, pad released
//   TX    | drive frame MSB first, pad_oe=1
//   RX    | sample frame from pad_i, pad_oe=0
//   TURN  | oe-low gap before the pad can be reused
module iobuf_ctrl
    import iobuf_ctrl_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BIT_CYCLES  = DEF_BIT_CYCLES,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              rx_req,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_perr,
    output logic              pad_o,
    output logic              pad_oe,
    input  logic              pad_i,
    output logic              busy
);

`ifdef IOBUF_CTRL_PARITY_EN
    localparam int NB = DATA_W + 1;
`else
    localparam int NB = DATA_W;
`endif
    localparam int TW = cnt_w(TURN_CYCLES);
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);

    state_e            state_q;
    logic              prio_tx_q;
    logic [NB-1:0]     sh_q;
    logic [TW-1:0]     turn_q;
    logic              pad_o_q;
    logic              pad_oe_q;
    logic              rx_valid_q;
    logic [DATA_W-1:0] rx_data_q;

    logic          tx_grant;
    logic          rx_grant;
    logic          bit_strobe;
    logic          sample_strobe;
    logic          last_bit;
    logic [NB-1:0] tx_frame;
    logic [NB-1:0] rx_shift;
    logic [NB-1:0] rx_frame;

`ifdef IOBUF_CTRL_PARITY_EN
    logic rx_perr_q;
    assign tx_frame = {tx_data, ^tx_data};
    assign rx_perr  = rx_perr_q;
`else
    assign tx_frame = tx_data;
    assign rx_perr  = 1'b0;
`endif

    always_comb begin
        tx_grant = (state_q == ST_IDLE) && tx_valid && (!rx_req || prio_tx_q);
        rx_grant = (state_q == ST_IDLE) && rx_req && (!tx_valid || !prio_tx_q);
        rx_shift = (sh_q << 1) | NB'(pad_i);
        // with BIT_CYCLES==2 the last sample lands on the final cycle, so bypass it
        rx_frame = sample_strobe ? rx_shift : sh_q;
    end

    iobuf_ctrl_timer #(
        .BIT_CYCLES(BIT_CYCLES),
        .NBITS     (NB)
    ) u_timer (
        .clk            (clk),
        .rst            (rst),
        .start_i        (tx_grant || rx_grant),
        .run_i          ((state_q == ST_TX) || (state_q == ST_RX)),
        .bit_strobe_o   (bit_strobe),
        .sample_strobe_o(sample_strobe),
        .last_bit_o     (last_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prio_tx_q  <= 1'b1;
            sh_q       <= '0;
            turn_q     <= '0;
            pad_o_q    <= 1'b0;
            pad_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
`ifdef IOBUF_CTRL_PARITY_EN
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_grant) begin
                        state_q   <= ST_TX;
                        prio_tx_q <= 1'b0;
                        pad_oe_q  <= 1'b1;
                        pad_o_q   <= tx_frame[NB-1];
                        sh_q      <= tx_frame << 1;
                    end else if (rx_grant) begin
                        state_q   <= ST_RX;
                        prio_tx_q <= 1'b1;
                        sh_q      <= '0;
                    end
                end
                ST_TX: begin
                    if (bit_strobe) begin
                        if (last_bit) begin
                            state_q  <= ST_TURN;
                            turn_q   <= TURN_LOAD;
                            pad_oe_q <= 1'b0;
                            pad_o_q  <= 1'b0;
                        end else begin
                            pad_o_q <= sh_q[NB-1];
                            sh_q    <= sh_q << 1;
                        end
                    end
                end
                ST_RX: begin
                    if (sample_strobe) sh_q <= rx_shift;
                    if (bit_strobe && last_bit) begin
                        state_q    <= ST_TURN;
                        turn_q     <= TURN_LOAD;
                        rx_valid_q <= 1'b1;
`ifdef IOBUF_CTRL_PARITY_EN
                        rx_data_q  <= rx_frame[NB-1:1];
                        rx_perr_q  <= ^rx_frame;
`else
                        rx_data_q  <= rx_frame;
`endif
                    end
                end
                ST_TURN: begin
                    if (turn_q == '0) state_q <= ST_IDLE;
                    else              turn_q  <= turn_q - TW'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_ready = (state_q == ST_IDLE) && (!rx_req || prio_tx_q);
    assign busy     = (state_q != ST_IDLE);
    assign pad_o    = pad_o_q;
    assign pad_oe   = pad_oe_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule
